acq_sequencer: RTL and testbench
================================

Name: acq_sequencer

Overview:
- Controller for the event-tagger timer register, which sits at register-bus address 1 (bit0 capture_operate, bit1 counter_operate, bit2 reset_counter).
- Runs a timed acquisition by issuing writes on the shared 8-bit register bus: reset counter, arm, run for N cycles or M records, stop.
- Arbitrates that bus between itself and the host register-write path. Sits between the host command decoder and the register bus feeding the tagger.

Parameters:
- TIMER_ADDR, 1: register-bus address of the timer control register.
- DUR_W, 32: width of the duration and elapsed counters.
- CNT_W, 32: width of the record limit and record counter.
- RESET_HOLD, 2: cycles the reset_counter value is held before arming; must be >=1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  single-cycle request to begin an acquisition.
- abort  in  1  single-cycle request to end the acquisition early.
- duration  in  DUR_W  RUN length in clk cycles; 0 = unlimited. Sampled at start acceptance.
- max_records  in  CNT_W  record limit; 0 = unlimited. Sampled at start acceptance.
- data_rdy  in  1  record strobe from the tagger.
- host_reg_addr  in  8  host register-write address; 0 = no write.
- host_reg_data  in  8  host register-write data.
- reg_addr  out  8  register-bus address to all register instances.
- reg_data  out  8  register-bus data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the acquisition completes.
- stop_reason  out  2  0 = duration, 1 = records, 2 = abort, 3 = none yet.
- record_count  out  CNT_W  records seen in the current or last run.
- elapsed  out  DUR_W  RUN cycles in the current or last run.
- host_conflict  out  1  one-cycle pulse when a host write is dropped.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; reg_addr=0, reg_data=0, busy=0, done=0, host_conflict=0, stop_reason=3, record_count=0, elapsed=0. Reset mid-run drops to IDLE with no STOP write issued; the system reset also clears the timer register.
- All outputs are registered.
- States:
  - IDLE: start=1 and abort=0 → RESET_CTR. Captures duration and max_records; clears record_count and elapsed; stop_reason=3. Simultaneous start+abort: abort wins, stay IDLE.
  - RESET_CTR: drives reg_addr=TIMER_ADDR, reg_data=0x04 for exactly RESET_HOLD cycles, then → ARM. abort → STOP (stop_reason=2).
  - ARM: drives TIMER_ADDR/0x03 for one cycle, then → RUN. abort → STOP (stop_reason=2).
  - RUN: the sequencer does not own the bus. elapsed increments each cycle, wrapping only if duration=0.
    - duration!=0 and elapsed==duration-1 → STOP, reason 0. RUN therefore lasts exactly duration cycles.
    - max_records!=0 and the registered record_count reaches max_records → STOP, reason 1.
    - abort → STOP, reason 2.
    - Priority when several hold in the same cycle: abort > records > duration.
  - STOP: drives TIMER_ADDR/0x00 for one cycle → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Latency: start accepted at edge t gives 0x04 on the bus in cycles t+1..t+RESET_HOLD, 0x03 at t+RESET_HOLD+1, and RUN from t+RESET_HOLD+2. done is asserted 2 cycles after the last RUN cycle.
- Record counting: data_rdy increments record_count in RUN and STOP only; ignored elsewhere. Saturates at all-ones.
- Bus arbitration:
  - In sequencer-write cycles (RESET_CTR, ARM, STOP) the sequencer owns the bus. A host write (host_reg_addr!=0) in such a cycle is dropped and host_conflict pulses.
  - In other states the host bus passes through, registered (1-cycle latency), except that a host write to TIMER_ADDR while busy is replaced by addr 0 and host_conflict pulses.
  - Host writes to TIMER_ADDR in IDLE pass through.
- start while busy is ignored. abort in IDLE, DONE or STOP is ignored.

Decomposition:
- Shared package acq_pkg: state enum (IDLE, RESET_CTR, ARM, RUN, STOP, DONE); timer bit constants CAPTURE_BIT=0, COUNTER_BIT=1, RESET_BIT=2; values TIMER_RESET=8'h04, TIMER_RUN=8'h03, TIMER_OFF=8'h00; stop_reason codes.
- Sub-module acq_bus_mux: the registered host/sequencer bus arbiter plus host_conflict generation. The FSM and counters stay in the top.

Test Plan:
- Reset then idle: rst_n low 3 cycles → all outputs at their reset values; host write addr 5 / data 0xAA appears on reg_addr/reg_data one cycle later.
- Timed run: duration=10, max_records=0, RESET_HOLD=2, start at t → 0x04 at t+1,t+2; 0x03 at t+3; RUN t+4..t+13; 0x00 at t+14; done at t+15; elapsed=10, stop_reason=0.
- Record limit: duration=0, max_records=3, three data_rdy pulses in RUN → STOP write follows, record_count=3, stop_reason=1. A data_rdy during the STOP cycle gives record_count=4.
- Abort: abort during RESET_CTR → next cycle 0x00 write, then done, stop_reason=2. Simultaneous start+abort in IDLE → stays IDLE, no bus activity.
- Arbitration: host write to addr 1 during RUN → reg_addr=0 and host_conflict pulse. Host write to addr 3 during ARM → dropped with a pulse. Host write to addr 3 during RUN → passes through.
- Mid-run reset: rst_n low during RUN → next cycle IDLE, busy=0, no done pulse.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sequencer and its bus arbiter.
// Timer register bit layout lives here so every consumer agrees on it.
package acq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET_CTR,
    ARM,
    RUN,
    STOP,
    DONE
  } acq_state_e;

  typedef enum logic [1:0] {
    REASON_DURATION = 2'd0,
    REASON_RECORDS  = 2'd1,
    REASON_ABORT    = 2'd2,
    REASON_NONE     = 2'd3
  } stop_reason_e;

  localparam int CAPTURE_BIT = 0;
  localparam int COUNTER_BIT = 1;
  localparam int RESET_BIT   = 2;

  localparam logic [7:0] TIMER_RESET = 8'h04;
  localparam logic [7:0] TIMER_RUN   = 8'h03;
  localparam logic [7:0] TIMER_OFF   = 8'h00;

  // States in which the sequencer itself drives the timer register.
  function automatic logic is_seq_write(input acq_state_e s);
    return (s == RESET_CTR) || (s == ARM) || (s == STOP);
  endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// Command, record-strobe and register-bus signals of the acquisition sequencer.
// The slave modport is the sequencer's view; master is the host/tagger side.
interface acq_sequencer_if #(
  parameter int DUR_W = 32,
  parameter int CNT_W = 32
);

  logic             start;
  logic             abort;
  logic [DUR_W-1:0] duration;
  logic [CNT_W-1:0] max_records;
  logic             data_rdy;
  logic [7:0]       host_reg_addr;
  logic [7:0]       host_reg_data;
  logic [7:0]       reg_addr;
  logic [7:0]       reg_data;
  logic             busy;
  logic             done;
  logic [1:0]       stop_reason;
  logic [CNT_W-1:0] record_count;
  logic [DUR_W-1:0] elapsed;
  logic             host_conflict;

  modport slave (
    input  start, abort, duration, max_records, data_rdy, host_reg_addr, host_reg_data,
    output reg_addr, reg_data, busy, done, stop_reason, record_count, elapsed, host_conflict
  );

  modport master (
    output start, abort, duration, max_records, data_rdy, host_reg_addr, host_reg_data,
    input  reg_addr, reg_data, busy, done, stop_reason, record_count, elapsed, host_conflict
  );

endinterface

// File: rtl/acq_bus_mux.sv
// Registered arbiter for the shared register bus: sequencer writes win over
// the host, and host writes to the timer register are blocked while busy.
module acq_bus_mux
  import acq_pkg::*;
#(
  parameter logic [7:0] TIMER_ADDR = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  acq_state_e state,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       host_conflict
);

  logic [7:0] addr_d;
  logic [7:0] data_d;
  logic       conflict_d;

  always_comb begin
    addr_d     = host_addr;
    data_d     = host_data;
    conflict_d = 1'b0;
    if (is_seq_write(state)) begin
      addr_d     = TIMER_ADDR;
      conflict_d = (host_addr != 8'h00);
      case (state)
        RESET_CTR: data_d = TIMER_RESET;
        ARM:       data_d = TIMER_RUN;
        default:   data_d = TIMER_OFF;
      endcase
    end else if (state != IDLE && host_addr == TIMER_ADDR) begin
      // The host may not touch the timer behind the sequencer's back.
      addr_d     = 8'h00;
      data_d     = 8'h00;
      conflict_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_addr      <= 8'h00;
      reg_data      <= 8'h00;
      host_conflict <= 1'b0;
    end else begin
      reg_addr      <= addr_d;
      reg_data      <= data_d;
      host_conflict <= conflict_d;
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// Timed acquisition controller: resets, arms, runs and stops the event-tagger
// timer over the shared register bus, tracking elapsed cycles and records.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter logic [7:0] TIMER_ADDR = 8'h01,
  parameter int         DUR_W      = 32,
  parameter int         CNT_W      = 32,
  parameter int         RESET_HOLD = 2
) (
  input logic             clk,
  input logic             rst_n,
  acq_sequencer_if.slave  bus
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  acq_state_e       state;
  acq_state_e       next_state;
  stop_reason_e     reason_q;
  stop_reason_e     reason_d;
  logic [DUR_W-1:0] dur_q;
  logic [CNT_W-1:0] max_q;
  logic [DUR_W-1:0] elapsed_q;
  logic [CNT_W-1:0] record_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic             busy_q;
  logic             done_q;
  logic             accept;

  assign accept = (state == IDLE) && bus.start && !bus.abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      reason_q <= REASON_NONE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= next_state;
      reason_q <= reason_d;
      busy_q   <= (next_state != IDLE);
      done_q   <= (state == DONE);
    end
  end

  // Stop conditions in RUN are ordered abort > records > duration.
  always_comb begin
    next_state = state;
    reason_d   = reason_q;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = RESET_CTR;
          reason_d   = REASON_NONE;
        end
      end
      RESET_CTR: begin
        if (bus.abort) begin
          next_state = STOP;
          reason_d   = REASON_ABORT;
        end else if (hold_cnt == HOLD_LAST) begin
          next_state = ARM;
        end
      end
      ARM: begin
        if (bus.abort) begin
          next_state = STOP;
          reason_d   = REASON_ABORT;
        end else begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          next_state = STOP;
          reason_d   = REASON_ABORT;
        end else if (max_q != '0 && record_q >= max_q) begin
          next_state = STOP;
          reason_d   = REASON_RECORDS;
        end else if (dur_q != '0 && elapsed_q == dur_q - DUR_W'(1)) begin
          next_state = STOP;
          reason_d   = REASON_DURATION;
        end
      end
      STOP:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dur_q     <= '0;
      max_q     <= '0;
      elapsed_q <= '0;
      record_q  <= '0;
      hold_cnt  <= '0;
    end else if (accept) begin
      dur_q     <= bus.duration;
      max_q     <= bus.max_records;
      elapsed_q <= '0;
      record_q  <= '0;
      hold_cnt  <= '0;
    end else begin
      if (state == RESET_CTR)
        hold_cnt <= hold_cnt + HOLD_W'(1);
      if (state == RUN)
        elapsed_q <= elapsed_q + DUR_W'(1);
      // Records arriving while the stop write is in flight still count.
      if ((state == RUN || state == STOP) && bus.data_rdy && record_q != '1)
        record_q <= record_q + CNT_W'(1);
    end
  end

  acq_bus_mux #(
    .TIMER_ADDR (TIMER_ADDR)
  ) u_bus_mux (
    .clk           (clk),
    .rst_n         (rst_n),
    .state         (state),
    .host_addr     (bus.host_reg_addr),
    .host_data     (bus.host_reg_data),
    .reg_addr      (bus.reg_addr),
    .reg_data      (bus.reg_data),
    .host_conflict (bus.host_conflict)
  );

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.stop_reason  = reason_q;
  assign bus.record_count = record_q;
  assign bus.elapsed      = elapsed_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed testbench for acq_sequencer with hand-computed cycle-by-cycle expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_acq_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  acq_sequencer_if #(.DUR_W(32), .CNT_W(32)) bus ();

  acq_sequencer #(
    .TIMER_ADDR (8'h01),
    .DUR_W      (32),
    .CNT_W      (32),
    .RESET_HOLD (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge (edge t).
  task automatic start_run(input logic [31:0] dur, input logic [31:0] recs);
    bus.duration    = dur;
    bus.max_records = recs;
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.reg_addr !== 8'h00) $display("[TB] FAIL reset_reg_addr: got %0h want 0", bus.reg_addr); else passes++;
    checks++; if (bus.reg_data !== 8'h00) $display("[TB] FAIL reset_reg_data: got %0h want 0", bus.reg_data); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", bus.done); else passes++;
    checks++; if (bus.host_conflict !== 1'b0) $display("[TB] FAIL reset_conflict: got %b want 0", bus.host_conflict); else passes++;
    checks++; if (bus.stop_reason !== 2'd3) $display("[TB] FAIL reset_stop_reason: got %0d want 3", bus.stop_reason); else passes++;
    checks++; if (bus.record_count !== 32'd0) $display("[TB] FAIL reset_record_count: got %0d want 0", bus.record_count); else passes++;
    checks++; if (bus.elapsed !== 32'd0) $display("[TB] FAIL reset_elapsed: got %0d want 0", bus.elapsed); else passes++;
    rst_n = 1'b1;
    bus.host_reg_addr = 8'h05;
    bus.host_reg_data = 8'hAA;
    tick();
    checks++; if (bus.reg_addr !== 8'h05) $display("[TB] FAIL idle_pass_addr: got %0h want 05", bus.reg_addr); else passes++;
    checks++; if (bus.reg_data !== 8'hAA) $display("[TB] FAIL idle_pass_data: got %0h want aa", bus.reg_data); else passes++;
    checks++; if (bus.host_conflict !== 1'b0) $display("[TB] FAIL idle_pass_conflict: got %b want 0", bus.host_conflict); else passes++;
    bus.host_reg_addr = 8'h00;
    bus.host_reg_data = 8'h00;
    tick();
  endtask

  task automatic test_timed_run();
    logic [7:0] exp_addr;
    logic [7:0] exp_data;
    logic       exp_done;
    logic       exp_busy;
    start_run(32'd10, 32'd0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp_addr = (k <= 3 || k == 14) ? 8'h01 : 8'h00;
      exp_data = (k <= 2) ? 8'h04 : (k == 3) ? 8'h03 : 8'h00;
      exp_done = (k == 15);
      exp_busy = (k <= 14);
      checks++; if (bus.reg_addr !== exp_addr) $display("[TB] FAIL timed_addr t+%0d: got %0h want %0h", k, bus.reg_addr, exp_addr); else passes++;
      checks++; if (bus.reg_data !== exp_data) $display("[TB] FAIL timed_data t+%0d: got %0h want %0h", k, bus.reg_data, exp_data); else passes++;
      checks++; if (bus.done !== exp_done) $display("[TB] FAIL timed_done t+%0d: got %b want %b", k, bus.done, exp_done); else passes++;
      checks++; if (bus.busy !== exp_busy) $display("[TB] FAIL timed_busy t+%0d: got %b want %b", k, bus.busy, exp_busy); else passes++;
    end
    checks++; if (bus.elapsed !== 32'd10) $display("[TB] FAIL timed_elapsed: got %0d want 10", bus.elapsed); else passes++;
    checks++; if (bus.stop_reason !== 2'd0) $display("[TB] FAIL timed_stop_reason: got %0d want 0", bus.stop_reason); else passes++;
    tick();
  endtask

  task automatic test_record_limit();
    start_run(32'd0, 32'd3);
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      bus.data_rdy = 1'b1;
      tick();
      bus.data_rdy = 1'b0;
      if (i < 2) tick();
    end
    checks++; if (bus.record_count !== 32'd3) $display("[TB] FAIL rec_count_three: got %0d want 3", bus.record_count); else passes++;
    tick();
    checks++; if (bus.reg_addr !== 8'h00) $display("[TB] FAIL rec_pre_stop_addr: got %0h want 0", bus.reg_addr); else passes++;
    bus.data_rdy = 1'b1;
    tick();
    bus.data_rdy = 1'b0;
    checks++; if (bus.reg_addr !== 8'h01) $display("[TB] FAIL rec_stop_addr: got %0h want 01", bus.reg_addr); else passes++;
    checks++; if (bus.reg_data !== 8'h00) $display("[TB] FAIL rec_stop_data: got %0h want 0", bus.reg_data); else passes++;
    checks++; if (bus.record_count !== 32'd4) $display("[TB] FAIL rec_count_stop: got %0d want 4", bus.record_count); else passes++;
    tick();
    checks++; if (bus.done !== 1'b1) $display("[TB] FAIL rec_done: got %b want 1", bus.done); else passes++;
    checks++; if (bus.stop_reason !== 2'd1) $display("[TB] FAIL rec_stop_reason: got %0d want 1", bus.stop_reason); else passes++;
    tick();
  endtask

  task automatic test_abort();
    start_run(32'd5, 32'd0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++; if (bus.reg_data !== 8'h04) $display("[TB] FAIL abort_reset_data: got %0h want 04", bus.reg_data); else passes++;
    tick();
    checks++; if (bus.reg_addr !== 8'h01) $display("[TB] FAIL abort_stop_addr: got %0h want 01", bus.reg_addr); else passes++;
    checks++; if (bus.reg_data !== 8'h00) $display("[TB] FAIL abort_stop_data: got %0h want 0", bus.reg_data); else passes++;
    tick();
    checks++; if (bus.done !== 1'b1) $display("[TB] FAIL abort_done: got %b want 1", bus.done); else passes++;
    checks++; if (bus.stop_reason !== 2'd2) $display("[TB] FAIL abort_stop_reason: got %0d want 2", bus.stop_reason); else passes++;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL start_abort_busy: got %b want 0", bus.busy); else passes++;
    tick();
    checks++; if (bus.reg_addr !== 8'h00) $display("[TB] FAIL start_abort_addr: got %0h want 0", bus.reg_addr); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL start_abort_busy2: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.stop_reason !== 2'd2) $display("[TB] FAIL start_abort_reason: got %0d want 2", bus.stop_reason); else passes++;
  endtask

  task automatic test_arbitration();
    start_run(32'd20, 32'd0);
    repeat (2) tick();
    bus.host_reg_addr = 8'h03;
    bus.host_reg_data = 8'h77;
    tick();
    checks++; if (bus.reg_addr !== 8'h01) $display("[TB] FAIL arb_arm_addr: got %0h want 01", bus.reg_addr); else passes++;
    checks++; if (bus.reg_data !== 8'h03) $display("[TB] FAIL arb_arm_data: got %0h want 03", bus.reg_data); else passes++;
    checks++; if (bus.host_conflict !== 1'b1) $display("[TB] FAIL arb_arm_conflict: got %b want 1", bus.host_conflict); else passes++;
    bus.host_reg_addr = 8'h01;
    bus.host_reg_data = 8'h55;
    tick();
    checks++; if (bus.reg_addr !== 8'h00) $display("[TB] FAIL arb_timer_addr: got %0h want 0", bus.reg_addr); else passes++;
    checks++; if (bus.host_conflict !== 1'b1) $display("[TB] FAIL arb_timer_conflict: got %b want 1", bus.host_conflict); else passes++;
    bus.host_reg_addr = 8'h03;
    bus.host_reg_data = 8'h5A;
    tick();
    checks++; if (bus.reg_addr !== 8'h03) $display("[TB] FAIL arb_pass_addr: got %0h want 03", bus.reg_addr); else passes++;
    checks++; if (bus.reg_data !== 8'h5A) $display("[TB] FAIL arb_pass_data: got %0h want 5a", bus.reg_data); else passes++;
    checks++; if (bus.host_conflict !== 1'b0) $display("[TB] FAIL arb_pass_conflict: got %b want 0", bus.host_conflict); else passes++;
    bus.host_reg_addr = 8'h00;
    bus.host_reg_data = 8'h00;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
    checks++; if (bus.reg_addr !== 8'h01) $display("[TB] FAIL arb_stop_addr: got %0h want 01", bus.reg_addr); else passes++;
    tick();
    checks++; if (bus.done !== 1'b1) $display("[TB] FAIL arb_done: got %b want 1", bus.done); else passes++;
    checks++; if (bus.elapsed !== 32'd3) $display("[TB] FAIL arb_elapsed: got %0d want 3", bus.elapsed); else passes++;
    checks++; if (bus.stop_reason !== 2'd2) $display("[TB] FAIL arb_stop_reason: got %0d want 2", bus.stop_reason); else passes++;
    tick();
  endtask

  task automatic test_mid_run_reset();
    start_run(32'd0, 32'd0);
    repeat (5) tick();
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL midrst_busy_run: got %b want 1", bus.busy); else passes++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.elapsed !== 32'd0) $display("[TB] FAIL midrst_elapsed: got %0d want 0", bus.elapsed); else passes++;
    checks++; if (bus.stop_reason !== 2'd3) $display("[TB] FAIL midrst_reason: got %0d want 3", bus.stop_reason); else passes++;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (bus.done !== 1'b0) $display("[TB] FAIL midrst_done +%0d: got %b want 0", k, bus.done); else passes++;
      checks++; if (bus.reg_addr !== 8'h00) $display("[TB] FAIL midrst_addr +%0d: got %0h want 0", k, bus.reg_addr); else passes++;
    end
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.duration      = 32'd0;
    bus.max_records   = 32'd0;
    bus.data_rdy      = 1'b0;
    bus.host_reg_addr = 8'h00;
    bus.host_reg_data = 8'h00;
    test_reset();
    test_timed_run();
    test_record_limit();
    test_abort();
    test_arbitration();
    test_mid_run_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
